// File: rtl/sma_pkg.sv
// Shared types and constants for the multi-channel moving-average scheduler.
package sma_pkg;

    typedef enum logic [1:0] {
        SMA_IDLE,
        SMA_UPDATE,
        SMA_DIVIDE,
        SMA_OUTPUT
    } sma_state_e;

    localparam int SMA_DEF_CHANNELS = 4;
    localparam int SMA_DEF_WINDOW   = 4;
    localparam int SMA_DEF_DATA_W   = 8;

    // Width that holds WINDOW full-scale samples without overflow.
    function automatic int sma_sum_w(input int data_w, input int window);
        return data_w + $clog2(window);
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle over N_W cycles.
// done_o flags the final iteration; quotient_o is valid in that same cycle.
module seq_udiv #(
    parameter int N_W = 10,
    parameter int D_W = 3,
    parameter int Q_W = N_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear_i,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [Q_W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(N_W + 1);

    logic [N_W-1:0]   quo_q, quo_d;
    logic [D_W-1:0]   rem_q, rem_d;
    logic [D_W-1:0]   div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [D_W:0]     rem_shift;
    logic             ge;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rem_shift = {rem_q, quo_q[N_W-1]};
        ge        = rem_shift >= {1'b0, div_q};
        // A successful subtract always leaves a remainder below the divisor, so D_W bits suffice.
        rem_d     = ge ? (rem_shift[D_W-1:0] - div_q) : rem_shift[D_W-1:0];
        quo_d     = {quo_q[N_W-2:0], ge};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else if (clear_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(N_W);
            quo_q  <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = quo_d[Q_W-1:0];

endmodule

// File: rtl/sma_channel_scheduler.sv
// Round-robin scheduler sharing one sliding-window SMA datapath across CHANNELS feeds.
// Define SMA_SCHED_PRIME_GATE_EN to suppress outputs until a channel's window has filled.
module sma_channel_scheduler
    import sma_pkg::*;
#(
    parameter int CHANNELS = SMA_DEF_CHANNELS,
    parameter int WINDOW   = SMA_DEF_WINDOW,
    parameter int DATA_W   = SMA_DEF_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic [CHANNELS-1:0]          in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(CHANNELS)-1:0]  out_chan,
    output logic                         out_primed
);

    localparam int SUM_W = sma_sum_w(DATA_W, WINDOW);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int PTR_W = $clog2(WINDOW);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WINDOW);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WINDOW - 1);

`ifdef SMA_SCHED_PRIME_GATE_EN
    localparam bit PRIME_GATE = 1'b1;
`else
    localparam bit PRIME_GATE = 1'b0;
`endif

    sma_state_e        state_q;
    logic [CH_W-1:0]   last_grant_q;
    logic [CH_W-1:0]   chan_q;
    logic [DATA_W-1:0] sample_q;
    logic [SUM_W-1:0]  sum_q  [CHANNELS];
    logic [DATA_W-1:0] buf_q  [CHANNELS][WINDOW];
    logic [PTR_W-1:0]  wptr_q [CHANNELS];
    logic [CNT_W-1:0]  cnt_q  [CHANNELS];
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_chan_q;
    logic              out_primed_q;

    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   cand;
    logic              grant_found;
    logic [DATA_W-1:0] grant_data;

    // Walk from farthest to nearest so the channel just after last_grant wins.
    always_comb begin
        grant_idx   = last_grant_q;
        grant_found = 1'b0;
        cand        = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            cand = CH_W'((int'(last_grant_q) + i) % CHANNELS);
            if (in_valid[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
        grant_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CH_W'(c) == grant_idx) begin
                grant_data = in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready = (state_q == SMA_IDLE && grant_found) ? (CHANNELS'(1) << grant_idx) : '0;

    logic [DATA_W-1:0] old_sample;
    logic [SUM_W-1:0]  sum_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [PTR_W-1:0]  wptr_d;
    logic              primed_d;

    always_comb begin
        old_sample = buf_q[chan_q][wptr_q[chan_q]];
        // Modular arithmetic: an intermediate wrap cancels because the final sum always fits.
        sum_d      = sum_q[chan_q] + SUM_W'(sample_q) - SUM_W'(old_sample);
        cnt_d      = (cnt_q[chan_q] == CNT_FULL) ? CNT_FULL : cnt_q[chan_q] + CNT_W'(1);
        wptr_d     = (wptr_q[chan_q] == PTR_LAST) ? '0 : wptr_q[chan_q] + PTR_W'(1);
        primed_d   = (cnt_d == CNT_FULL);
    end

    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_quo;

    assign div_start = (state_q == SMA_UPDATE) && !clr && (!PRIME_GATE || primed_d);

    seq_udiv #(
        .N_W (SUM_W),
        .D_W (CNT_W),
        .Q_W (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clr),
        .start_i    (div_start),
        .dividend_i (sum_d),
        .divisor_i  (CNT_FULL),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SMA_IDLE;
            last_grant_q <= CH_W'(CHANNELS - 1);
            chan_q       <= '0;
            sample_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_primed_q <= 1'b0;
            // NOTE: the window buffers are reset because unprimed averages read them as zeros.
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c]  <= '0;
                wptr_q[c] <= '0;
                cnt_q[c]  <= '0;
                for (int w = 0; w < WINDOW; w++) begin
                    buf_q[c][w] <= '0;
                end
            end
        end else if (clr) begin
            state_q     <= SMA_IDLE;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c]  <= '0;
                wptr_q[c] <= '0;
                cnt_q[c]  <= '0;
                for (int w = 0; w < WINDOW; w++) begin
                    buf_q[c][w] <= '0;
                end
            end
        end else begin
            case (state_q)
                SMA_IDLE: begin
                    if (grant_found) begin
                        chan_q       <= grant_idx;
                        sample_q     <= grant_data;
                        last_grant_q <= grant_idx;
                        state_q      <= SMA_UPDATE;
                    end
                end
                SMA_UPDATE: begin
                    sum_q[chan_q]                 <= sum_d;
                    buf_q[chan_q][wptr_q[chan_q]] <= sample_q;
                    wptr_q[chan_q]                <= wptr_d;
                    cnt_q[chan_q]                 <= cnt_d;
                    state_q <= (PRIME_GATE && !primed_d) ? SMA_IDLE : SMA_DIVIDE;
                end
                SMA_DIVIDE: begin
                    if (div_busy && div_done) begin
                        out_valid_q  <= 1'b1;
                        out_data_q   <= div_quo;
                        out_chan_q   <= chan_q;
                        out_primed_q <= (cnt_q[chan_q] == CNT_FULL);
                        state_q      <= SMA_OUTPUT;
                    end
                end
                SMA_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= SMA_IDLE;
                    end
                end
                default: state_q <= SMA_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign out_primed = PRIME_GATE ? 1'b1 : out_primed_q;

endmodule

// File: tb/tb_sma_channel_scheduler.sv
// Directed bench for sma_channel_scheduler: history-based reference model feeding a scoreboard.
module tb_sma_channel_scheduler;

    localparam int CHANNELS = 4;
    localparam int WINDOW   = 4;
    localparam int DATA_W   = 8;
    localparam int CH_W     = 2;
    localparam int SUM_W    = 10;
    localparam int LAT      = SUM_W + 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       clr;
    logic [CHANNELS-1:0]        in_valid;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic [CHANNELS-1:0]        in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [CH_W-1:0]            out_chan;
    logic                       out_primed;

    sma_channel_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_primed (out_primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int data;
        int primed;
    } exp_t;

    exp_t sb[$];
    int   hist[CHANNELS][$];
    int   out_log[$];
    int   primed_log[$];
    int   chan_log[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   xfer_cyc = 0;
    int   accept_cyc = 0;
    logic prev_valid = 1'b0;
    int   hold_data;
    int   hold_chan;
    int   n_before;
    int   n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: mean of the last WINDOW accepted samples, missing ones counted as zero.
    task automatic model_push(input int c, input int x);
        int   s;
        int   cnt;
        exp_t e;
        s = 0;
        hist[c].push_back(x);
        grant_log.push_back(c);
        xfer_cyc = cyc;
        cnt = hist[c].size();
        for (int k = (cnt > WINDOW) ? cnt - WINDOW : 0; k < cnt; k++) s += hist[c][k];
        e.chan   = c;
        e.data   = s / WINDOW;
        e.primed = (cnt >= WINDOW) ? 1 : 0;
`ifdef SMA_SCHED_PRIME_GATE_EN
        if (cnt >= WINDOW) sb.push_back(e);
`else
        sb.push_back(e);
`endif
    endtask

    task automatic flush();
        sb.delete();
        for (int c = 0; c < CHANNELS; c++) hist[c].delete();
    endtask

    always @(negedge clk) begin
        if (!rst && !clr) begin
            check("in_ready_onehot", 32'($onehot0(in_ready)), 1);
            for (int c = 0; c < CHANNELS; c++) begin
                if (in_valid[c] && in_ready[c]) model_push(c, int'(in_data[c*DATA_W +: DATA_W]));
            end
            if (out_valid && !prev_valid) check("latency", cyc - xfer_cyc, LAT);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_chan", 32'(out_chan), e.chan);
                    check("out_data", 32'(out_data), e.data);
                    check("out_primed", 32'(out_primed), e.primed);
                    out_log.push_back(int'(out_data));
                    primed_log.push_back(int'(out_primed));
                    chan_log.push_back(int'(out_chan));
                end
                accept_cyc = cyc;
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input int ch, input logic [DATA_W-1:0] val);
        int k;
        k = 0;
        @(posedge clk); #1;
        in_valid[ch] = 1'b1;
        in_data[ch*DATA_W +: DATA_W] = val;
        do begin
            @(negedge clk);
            k++;
        end while (in_ready[ch] !== 1'b1 && k < 200);
        check("send_grant", 32'(in_ready[ch]), 1);
        @(posedge clk); #1;
        in_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (out_valid !== 1'b1 && k < 200);
        check("wait_valid", 32'(out_valid), 1);
    endtask

    task automatic check_log(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            check($sformatf("%s[%0d]", tag, k), got[k], exp[k]);
        end
    endtask

    task automatic clear_logs();
        out_log.delete();
        primed_log.delete();
        chan_log.delete();
        grant_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        out_ready = 1'b1;
        in_valid = '0;
        in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_chan", 32'(out_chan), 0);
        check("rst_out_primed", 32'(out_primed), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fairness: every channel valid continuously for eight grants.
        clear_logs();
        for (int c = 0; c < CHANNELS; c++) in_data[c*DATA_W +: DATA_W] = 8'((c + 1) * 16);
        in_valid = '1;
        n = 0;
        while (grant_log.size() < 8 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        in_valid = '0;
        drain();
        check_log("grant", grant_log, '{0, 1, 2, 3, 0, 1, 2, 3});

        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        flush();

        // Channel 0 alone through the priming phase.
        clear_logs();
        send(0, 8'd10);
        send(0, 8'd20);
        send(0, 8'd30);
        send(0, 8'd40);
        send(0, 8'd50);
        drain();
`ifdef SMA_SCHED_PRIME_GATE_EN
        check_log("ch0_data", out_log, '{25, 35});
        check_log("ch0_primed", primed_log, '{1, 1});
`else
        check_log("ch0_data", out_log, '{2, 7, 15, 25, 35});
        check_log("ch0_primed", primed_log, '{0, 0, 0, 1, 1});
        check_log("ch0_chan", chan_log, '{0, 0, 0, 0, 0});

        // Full-scale samples: pointer wrap and maximum sum.
        clear_logs();
        for (int k = 0; k < 6; k++) send(2, 8'd255);
        drain();
        check_log("ch2_data", out_log, '{63, 127, 191, 255, 255, 255});

        // Backpressure on the result.
        clear_logs();
        out_ready = 1'b0;
        send(1, 8'd100);
        wait_valid();
        hold_data = int'(out_data);
        hold_chan = int'(out_chan);
        check("bp_first_data", hold_data, 25);
        @(posedge clk); #1;
        in_data[3*DATA_W +: DATA_W] = 8'd64;
        in_valid[3] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_data", 32'(out_data), hold_data);
            check("bp_chan", 32'(out_chan), hold_chan);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready[3] !== 1'b1 && n < 100);
        check("bp_next_xfer", cyc - accept_cyc, 1);
        @(posedge clk); #1;
        in_valid[3] = 1'b0;
        drain();
        check_log("bp_data_log", out_log, '{25, 16});

        // Reset in the middle of a division discards the result.
        send(1, 8'd200);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        flush();
        #1;
        check("rst_mid_valid", 32'(out_valid), 0);
        check("rst_mid_data", 32'(out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_before = out_log.size();
        repeat (20) @(negedge clk);
        check("rst_discard", out_log.size(), n_before);

        // After reset channel 0 has first priority.
        out_ready = 1'b0;
        in_data[0*DATA_W +: DATA_W] = 8'd80;
        in_data[3*DATA_W +: DATA_W] = 8'd44;
        @(posedge clk); #1;
        in_valid = 4'b1001;
        @(negedge clk);
        check("rst_priority", 32'(in_ready), 32'(4'b0001));
        @(posedge clk); #1;
        in_valid = '0;
        wait_valid();

        // Clear while holding a result drops it; last grant survives.
        @(posedge clk); #1;
        clr = 1'b1;
        flush();
        @(posedge clk); #1;
        check("clr_drop", 32'(out_valid), 0);
        clr = 1'b0;
        out_ready = 1'b1;
        in_valid = 4'b1001;
        @(negedge clk);
        check("clr_keeps_grant", 32'(in_ready), 32'(4'b1000));
        @(posedge clk); #1;
        in_valid = '0;
        drain();

        clear_logs();
        send(1, 8'd40);
        drain();
        check_log("post_clr_data", out_log, '{10});
        check_log("post_clr_primed", primed_log, '{0});
        check_log("post_clr_chan", chan_log, '{1});
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sma_channel_scheduler.md
# sma_channel_scheduler

Time-multiplexes one sliding-window moving-average engine across `CHANNELS` independent price feeds. Requesters are served round-robin over valid/ready handshakes, and each channel keeps its own window buffer and running sum. A single shared sequential divider produces each average. The block sits between the per-symbol market-data decoders and the strategy logic, and replaces N parallel SMA instances with one shared arithmetic path.

## Interface
- `CHANNELS`, 4: number of requesting feeds, ≥2.
- `WINDOW`, 4: samples per average, ≥2, any integer (not restricted to powers of 2).
- `DATA_W`, 8: price width.
- `SUM_W` (localparam) = `DATA_W + $clog2(WINDOW)`. `CH_W` (localparam) = `$clog2(CHANNELS)`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous clear of all channel state.
- `in_valid`  in  CHANNELS  per-channel sample offered.
- `in_data`  in  CHANNELS*DATA_W  flattened samples; channel c at `[c*DATA_W +: DATA_W]`.
- `in_ready`  out  CHANNELS  one-hot grant; a transfer occurs when `in_valid[c] & in_ready[c]`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  DATA_W  floor(sum/WINDOW).
- `out_chan`  out  CH_W  channel that owns `out_data`.
- `out_primed`  out  1  the channel has received at least WINDOW samples.

## Operation
- FSM states: IDLE → UPDATE → DIVIDE → OUTPUT → IDLE.
- **IDLE**
  - `in_ready` is combinational and one-hot to the round-robin winner among `in_valid`.
  - Search starts at `last_grant+1` and wraps modulo CHANNELS.
  - On transfer: latch the sample and channel, set `last_grant`, go to UPDATE.
  - `in_ready` is all-zero in every other state.
- **UPDATE**
  - `sum[c] <= sum[c] + x - buf[c][wptr[c]]`, zero-extended to SUM_W.
  - `buf[c][wptr[c]] <= x`.
  - `wptr[c]` increments and wraps from WINDOW-1 to 0.
  - `cnt[c]` increments and saturates at WINDOW.
- **DIVIDE**
  - Restoring unsigned division of the updated sum by WINDOW, one quotient bit per cycle, SUM_W cycles.
  - The quotient always fits in DATA_W bits, because the maximum sum is WINDOW·(2^DATA_W−1). Truncation to DATA_W is lossless.
- **OUTPUT**
  - Hold `out_valid`, `out_data`, `out_chan`, `out_primed` stable until `out_ready`.
  - On acceptance, go to IDLE.
- Unprimed channels: the buffer starts at zero, so early outputs average against zeros. `out_primed = (cnt[c]==WINDOW)` after the update.
- `clr` is honoured in any state and has priority over a transfer in the same cycle.
  - Zero all sums, buffers, pointers and counts.
  - Abort any in-flight operation, drop `out_valid`, go to IDLE.
  - `last_grant` is preserved.
- Reset values:
  - State IDLE; all sums, buffers, pointers and counts 0.
  - `last_grant = CHANNELS-1`, so channel 0 has first priority.
  - `out_valid=0`, `out_data=0`, `out_chan=0`, `out_primed=0`, `in_ready=0`.
- Reset asserted mid-DIVIDE or mid-OUTPUT: the result is discarded, with no partial output.

## Timing
- Cycle 0: transfer in IDLE.
- Cycle 1: UPDATE.
- Cycles 2..SUM_W+1: DIVIDE.
- `out_valid` rises at cycle SUM_W+2 (cycle 12 for the defaults).
- With `out_ready` held high: one OUTPUT cycle, IDLE at SUM_W+3, earliest next transfer at SUM_W+3. Minimum period is SUM_W+3 cycles per sample.
- Backpressure: each extra cycle with `out_ready` low adds one cycle. Outputs do not change while `out_valid & ~out_ready`.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,CHANNELS-1,0,…

## Configuration
- `SMA_SCHED_PRIME_GATE_EN` defined:
  - UPDATE goes directly to IDLE when the channel is not yet primed (`cnt<WINDOW` after update).
  - No output and no DIVIDE occur for that sample.
  - `out_primed` is tied to 1.
- `SMA_SCHED_PRIME_GATE_EN` not defined: every accepted sample produces exactly one output.

## Structure
- Package `sma_pkg`:
  - FSM state enum (`SMA_IDLE`, `SMA_UPDATE`, `SMA_DIVIDE`, `SMA_OUTPUT`).
  - Function computing SUM_W from DATA_W and WINDOW.
  - Default parameter constants.
- Sub-module `seq_udiv`, a restoring divider: parameters `N_W`/`D_W`, with `start`, `busy`, `done` and quotient outputs.
- Round-robin arbitration and channel state stay in the top module.

## Test plan
- Channel 0 alone sends 10,20,30,40,50 (defaults):
  - Outputs 2,7,15,25,35 with `out_chan=0`.
  - `out_primed` 0,0,0,1,1.
  - `out_valid` rises 12 cycles after each transfer.
- All 4 channels hold `in_valid` for 8 samples: grant order 0,1,2,3,0,1,2,3; no channel is starved.
- Channel 2 sends 255 ×6: outputs 63,127,191,255,255,255, covering pointer wrap and the maximum sum 1020.
- `out_ready` held low for 5 cycles in OUTPUT: `out_data`/`out_chan` stable, `in_ready` all-zero, next transfer only after acceptance.
- `rst` pulsed mid-DIVIDE, then `clr` pulsed mid-OUTPUT:
  - `out_valid` drops immediately on each.
  - The next sample 40 on channel 1 yields 10 with `out_primed=0`.
- Build with `SMA_SCHED_PRIME_GATE_EN`, then replay the first scenario: only outputs 25 and 35 appear.
